axi_engine_seq: RTL and testbench

//  Command sequencer directly upstream of axi_engine. Accepts one command (op, base address,

---
 rtl/axi_engine_seq.sv | 198 +++++++++++++++++++
 tb/tb_axi_engine_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_engine_seq.sv
// Command sequencer in front of axi_engine: expands one command into a
// strictly serialised train of single-beat engine operations with a stepped
// address, sourcing write data from an input stream and returning read data
// on an output stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a command, cmd_ready high
// S_GET_WD   | write beat: waiting for one word on the wdata stream
// S_ISSUE    | single cycle, pulse eng_start_wr/rd, load timeout timer
// S_WAIT_END | waiting for the matching eng_end_*, timer counting down
// S_PUSH_RD  | read beat: rdata held valid until rdata_ready
// S_DONE     | single cycle done pulse, then back to idle
module axi_engine_seq #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_is_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_num,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  eng_start_wr,
  output logic                  eng_start_rd,
  output logic [ADDR_WIDTH-1:0] eng_write_addr,
  output logic [ADDR_WIDTH-1:0] eng_read_addr,
  output logic [DATA_WIDTH-1:0] eng_write_data,
  input  logic                  eng_end_wr,
  input  logic                  eng_end_rd,
  input  logic [DATA_WIDTH-1:0] eng_read_data,
  output logic                  done,
  output logic                  err_timeout,
  output logic [CNT_WIDTH-1:0]  beats_done
);

  // Down-counter: loaded with TIMEOUT-1 in ISSUE, so WAIT_END lasts at most
  // TIMEOUT cycles before the terminal count aborts the sequence.
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_WD,
    S_ISSUE,
    S_WAIT_END,
    S_PUSH_RD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  beats_q, beats_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  live_q;
  logic                  beat_cmp;
  logic [CNT_WIDTH-1:0]  beats_inc;

  assign beats_inc = beats_q + 1'b1;

  // live_q holds cmd_ready low while reset is asserted and for the first
  // clock after release, so nothing is accepted on an unsettled cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) live_q <= 1'b0;
    else         live_q <= 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      num_q    <= '0;
      beats_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      num_q    <= num_d;
      beats_q  <= beats_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    num_d    = num_q;
    beats_d  = beats_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    timer_d  = timer_q;
    beat_cmp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          is_wr_d  = cmd_is_wr;
          addr_d   = cmd_addr;
          num_d    = cmd_num;
          stride_d = cmd_stride;
          beats_d  = '0;
          err_d    = 1'b0;
          if (cmd_num == '0)  state_d = S_DONE;
          else if (cmd_is_wr) state_d = S_GET_WD;
          else                state_d = S_ISSUE;
        end
      end
      S_GET_WD: begin
        if (wdata_valid) begin
          wdata_d = wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = TMR_LOAD;
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        // The end pulse of the opposite operation is deliberately ignored.
        if (is_wr_q && eng_end_wr) begin
          beat_cmp = 1'b1;
        end else if (!is_wr_q && eng_end_rd) begin
          rdata_d = eng_read_data;
          state_d = S_PUSH_RD;
        end else if (timer_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_PUSH_RD: begin
        if (rdata_ready) beat_cmp = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Address steps only after the engine has finished with it, which keeps
    // eng_*_addr stable from ISSUE through the end pulse.
    if (beat_cmp) begin
      beats_d = beats_inc;
      addr_d  = addr_q + stride_q;
      if (beats_inc == num_q) state_d = S_DONE;
      else if (is_wr_q)       state_d = S_GET_WD;
      else                    state_d = S_ISSUE;
    end
  end

  assign cmd_ready      = live_q & (state_q == S_IDLE);
  assign wdata_ready    = (state_q == S_GET_WD);
  assign rdata_valid    = (state_q == S_PUSH_RD);
  assign rdata          = rdata_q;
  assign eng_start_wr   = (state_q == S_ISSUE) & is_wr_q;
  assign eng_start_rd   = (state_q == S_ISSUE) & ~is_wr_q;
  assign eng_write_addr = addr_q;
  assign eng_read_addr  = addr_q;
  assign eng_write_data = wdata_q;
  assign done           = (state_q == S_DONE);
  assign err_timeout    = err_q;
  assign beats_done     = beats_q;

endmodule

// File: tb/tb_axi_engine_seq.sv
// Directed bench for axi_engine_seq with a behavioural axi_engine responder.
module tb_axi_engine_seq;

  localparam int AW = 33;
  localparam int DW = 256;
  localparam int CW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid, cmd_ready, cmd_is_wr;
  logic [AW-1:0] cmd_addr, cmd_stride;
  logic [CW-1:0] cmd_num;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready;
  logic [DW-1:0] rdata;
  logic          eng_start_wr, eng_start_rd;
  logic [AW-1:0] eng_write_addr, eng_read_addr;
  logic [DW-1:0] eng_write_data;
  logic          eng_end_wr, eng_end_rd;
  logic [DW-1:0] eng_read_data;
  logic          done, err_timeout;
  logic [CW-1:0] beats_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_engine_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_wr(cmd_is_wr),
    .cmd_addr(cmd_addr), .cmd_num(cmd_num), .cmd_stride(cmd_stride),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .eng_start_wr(eng_start_wr), .eng_start_rd(eng_start_rd),
    .eng_write_addr(eng_write_addr), .eng_read_addr(eng_read_addr),
    .eng_write_data(eng_write_data),
    .eng_end_wr(eng_end_wr), .eng_end_rd(eng_end_rd),
    .eng_read_data(eng_read_data),
    .done(done), .err_timeout(err_timeout), .beats_done(beats_done)
  );

  function automatic logic [DW-1:0] wr_pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {8{w}};
  endfunction

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = a[31:0] ^ 32'h5A5A_0000;
    return {a, 223'h0} ^ {8{w}};
  endfunction

  // Engine responder, write-data stream source and start/done monitor.
  int            eng_lat     = 5;
  int            suppress_at = -1;
  int            rd_starts   = 0;
  int            n_done      = 0;
  int            wd_idx      = 0;
  logic [AW-1:0] st_addr[$];
  logic [DW-1:0] st_data[$];
  bit            st_wr[$];
  int            st_cyc[$];

  initial begin
    int            cnt;
    bit            op_wr, sup, prev_hs;
    logic [AW-1:0] ea;
    cnt = 0; op_wr = 0; sup = 0; prev_hs = 0; ea = '0;
    eng_end_wr = 0; eng_end_rd = 0; eng_read_data = '0;
    wdata = wr_pat(0);
    forever begin
      @(posedge clk); #2;
      if (prev_hs) begin
        wd_idx++;
        wdata = wr_pat(wd_idx);
      end
      prev_hs = wdata_valid && wdata_ready;
      eng_end_wr = 0;
      eng_end_rd = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !sup) begin
          if (op_wr) eng_end_wr = 1;
          else begin
            eng_end_rd = 1;
            eng_read_data = rd_pat(ea);
          end
        end
      end
      if (eng_start_wr || eng_start_rd) begin
        ea = eng_start_wr ? eng_write_addr : eng_read_addr;
        st_addr.push_back(ea);
        st_data.push_back(eng_write_data);
        st_wr.push_back(eng_start_wr);
        st_cyc.push_back(cyc);
        op_wr = eng_start_wr;
        cnt = eng_lat;
        sup = 0;
        if (eng_start_rd) begin
          sup = (rd_starts == suppress_at);
          rd_starts++;
        end
      end
      if (done) n_done++;
    end
  end

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [CW-1:0] n,
                          input logic [AW-1:0] s, output int acc);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL cmd_ready_wait: got %0b exp 1", cmd_ready);
    end
    cmd_valid = 1; cmd_is_wr = wr; cmd_addr = a; cmd_num = n; cmd_stride = s;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int dcyc);
    seen = 0; dcyc = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done === 1'b1) begin
        seen = 1; dcyc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %0b exp 0", cmd_ready); end
    n_cmp++; if ({done, err_timeout, rdata_valid, wdata_ready, eng_start_wr, eng_start_rd} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b exp 000000",
                        {done, err_timeout, rdata_valid, wdata_ready, eng_start_wr, eng_start_rd});
    end
    n_cmp++; if (beats_done !== 16'd0) begin n_err++; $display("FAIL reset_beats: got %0d exp 0", beats_done); end
    n_cmp++; if (eng_write_addr !== 33'd0 || rdata !== 256'd0) begin
      n_err++; $display("FAIL reset_regs: got addr %0h rdata %0h exp 0", eng_write_addr, rdata);
    end
    resetn = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL idle_cmd_ready: got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_write;
    int b0, wb, d0, acc, dc;
    bit seen;
    logic [AW-1:0] ea;
    eng_lat = 5; wdata_valid = 1;
    b0 = st_addr.size(); wb = wd_idx; d0 = n_done;
    send_cmd(1, 33'h100, 16'd4, 33'h20, acc);
    wait_done(200, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL wr_done: got %0b exp 1", seen); end
    n_cmp++; if (beats_done !== 16'd4) begin n_err++; $display("FAIL wr_beats: got %0d exp 4", beats_done); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL wr_err: got %0b exp 0", err_timeout); end
    @(posedge clk); #1;
    wdata_valid = 0;
    n_cmp++; if (st_addr.size() - b0 !== 4) begin n_err++; $display("FAIL wr_nstart: got %0d exp 4", st_addr.size() - b0); end
    n_cmp++; if (n_done - d0 !== 1) begin n_err++; $display("FAIL wr_ndone: got %0d exp 1", n_done - d0); end
    n_cmp++; if (st_cyc[b0] - acc !== 1) begin n_err++; $display("FAIL wr_latency: got %0d exp 1", st_cyc[b0] - acc); end
    for (int i = 0; i < 4; i++) begin
      ea = 33'h100 + 33'(i) * 33'h20;
      n_cmp++; if (st_addr[b0+i] !== ea || st_wr[b0+i] !== 1'b1) begin
        n_err++; $display("FAIL wr_addr%0d: got %0h wr=%0b exp %0h wr=1", i, st_addr[b0+i], st_wr[b0+i], ea);
      end
      n_cmp++; if (st_data[b0+i] !== wr_pat(wb + i)) begin
        n_err++; $display("FAIL wr_data%0d: got %0h exp %0h", i, st_data[b0+i], wr_pat(wb + i));
      end
    end
  endtask

  task automatic test_read_backpressure;
    int b0, acc, dc, ns, viol, k;
    bit seen;
    logic [DW-1:0] held, exp_w;
    eng_lat = 3; rdata_ready = 0;
    b0 = st_addr.size();
    send_cmd(0, 33'h4000, 16'd3, 33'h40, acc);
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (rdata_valid !== 1'b1 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      n_cmp++; if (rdata_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid%0d: got %0b exp 1", i, rdata_valid); end
      if (i == 0) begin
        n_cmp++; if (cyc - st_cyc[b0] !== 4) begin n_err++; $display("FAIL rd_latency: got %0d exp 4", cyc - st_cyc[b0]); end
      end
      exp_w = rd_pat(33'h4000 + 33'(i) * 33'h40);
      n_cmp++; if (rdata !== exp_w) begin n_err++; $display("FAIL rd_word%0d: got %0h exp %0h", i, rdata, exp_w); end
      held = rdata; ns = st_addr.size(); viol = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (rdata !== held || rdata_valid !== 1'b1 || st_addr.size() != ns) viol++;
      end
      n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL rd_hold%0d: got %0d violations exp 0", i, viol); end
      rdata_ready = 1;
      @(posedge clk); #1;
      rdata_ready = 0;
      n_cmp++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL rd_drop%0d: got %0b exp 0", i, rdata_valid); end
    end
    wait_done(50, seen, dc);
    n_cmp++; if (seen !== 1'b1 || beats_done !== 16'd3) begin
      n_err++; $display("FAIL rd_done: got done=%0b beats=%0d exp done=1 beats=3", seen, beats_done);
    end
    @(posedge clk); #1;
    n_cmp++; if (st_addr.size() - b0 !== 3 || st_wr[b0] !== 1'b0) begin
      n_err++; $display("FAIL rd_nstart: got %0d wr=%0b exp 3 wr=0", st_addr.size() - b0, st_wr[b0]);
    end
  endtask

  task automatic test_zero_num;
    int b0, d0, acc, dc;
    bit seen;
    b0 = st_addr.size(); d0 = n_done;
    send_cmd(1, 33'h500, 16'd0, 33'h10, acc);
    wait_done(2, seen, dc);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL zero_done: got %0b exp 1 within 2 cycles", seen); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (st_addr.size() !== b0) begin n_err++; $display("FAIL zero_nstart: got %0d exp 0", st_addr.size() - b0); end
    n_cmp++; if (beats_done !== 16'd0) begin n_err++; $display("FAIL zero_beats: got %0d exp 0", beats_done); end
    n_cmp++; if (n_done - d0 !== 1) begin n_err++; $display("FAIL zero_ndone: got %0d exp 1", n_done - d0); end
  endtask

  task automatic test_wrap;
    int b0, acc, dc;
    bit seen;
    eng_lat = 2; rdata_ready = 1;
    b0 = st_addr.size();
    send_cmd(0, 33'h1_FFFF_FFE0, 16'd2, 33'h20, acc);
    wait_done(100, seen, dc);
    @(posedge clk); #1;
    rdata_ready = 0;
    n_cmp++; if (seen !== 1'b1 || beats_done !== 16'd2) begin
      n_err++; $display("FAIL wrap_done: got done=%0b beats=%0d exp done=1 beats=2", seen, beats_done);
    end
    n_cmp++; if (st_addr[b0] !== 33'h1_FFFF_FFE0) begin n_err++; $display("FAIL wrap_addr0: got %0h exp 1ffffffe0", st_addr[b0]); end
    n_cmp++; if (st_addr[b0+1] !== 33'h0) begin n_err++; $display("FAIL wrap_addr1: got %0h exp 0", st_addr[b0+1]); end
    n_cmp++; if (rdata !== rd_pat(33'h0)) begin n_err++; $display("FAIL wrap_rdata: got %0h exp %0h", rdata, rd_pat(33'h0)); end
  endtask

  task automatic test_timeout;
    int b0, acc, dc;
    bit seen;
    eng_lat = 2; rdata_ready = 1;
    b0 = st_addr.size();
    suppress_at = rd_starts + 1;
    send_cmd(0, 33'h2000, 16'd4, 33'h10, acc);
    wait_done(TO + 100, seen, dc);
    n_cmp++; if (seen !== 1'b1 || err_timeout !== 1'b1) begin
      n_err++; $display("FAIL to_done: got done=%0b err=%0b exp 1 1", seen, err_timeout);
    end
    n_cmp++; if (beats_done !== 16'd1) begin n_err++; $display("FAIL to_beats: got %0d exp 1", beats_done); end
    n_cmp++; if (dc - st_cyc[b0+1] !== TO + 1) begin
      n_err++; $display("FAIL to_cycles: got %0d exp %0d", dc - st_cyc[b0+1], TO + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    rdata_ready = 0;
    suppress_at = -1;
    n_cmp++; if (st_addr.size() - b0 !== 2) begin n_err++; $display("FAIL to_nstart: got %0d exp 2", st_addr.size() - b0); end
    n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %0b exp 1", err_timeout); end
    send_cmd(1, 33'h0, 16'd0, 33'h0, acc);
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %0b exp 0", err_timeout); end
    wait_done(5, seen, dc);
  endtask

  task automatic test_reset_mid;
    int d0, acc, dc;
    bit seen;
    eng_lat = 20; wdata_valid = 1;
    send_cmd(1, 33'h800, 16'd3, 33'h8, acc);
    repeat (5) @(posedge clk);
    #1;
    d0 = n_done;
    resetn = 0;
    #1;
    n_cmp++; if ({cmd_ready, wdata_ready, rdata_valid, eng_start_wr, eng_start_rd, done, err_timeout} !== 7'b0) begin
      n_err++; $display("FAIL mid_flags: got %b exp 0000000",
                        {cmd_ready, wdata_ready, rdata_valid, eng_start_wr, eng_start_rd, done, err_timeout});
    end
    n_cmp++; if (eng_write_addr !== 33'd0 || eng_read_addr !== 33'd0 || beats_done !== 16'd0) begin
      n_err++; $display("FAIL mid_addr: got %0h %0h beats %0d exp 0", eng_write_addr, eng_read_addr, beats_done);
    end
    n_cmp++; if (eng_write_data !== 256'd0 || rdata !== 256'd0) begin
      n_err++; $display("FAIL mid_data: got %0h %0h exp 0", eng_write_data, rdata);
    end
    @(posedge clk); #1;
    resetn = 1; wdata_valid = 0;
    repeat (25) @(posedge clk);
    #1;
    n_cmp++; if (n_done !== d0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_quiet: got ndone+%0d ready=%0b exp 0 1", n_done - d0, cmd_ready);
    end
    eng_lat = 2; rdata_ready = 1;
    send_cmd(0, 33'h3000, 16'd1, 33'h0, acc);
    wait_done(50, seen, dc);
    rdata_ready = 0;
    n_cmp++; if (seen !== 1'b1 || beats_done !== 16'd1 || err_timeout !== 1'b0) begin
      n_err++; $display("FAIL mid_rerun: got done=%0b beats=%0d err=%0b exp 1 1 0", seen, beats_done, err_timeout);
    end
    n_cmp++; if (rdata !== rd_pat(33'h3000)) begin n_err++; $display("FAIL mid_rdata: got %0h exp %0h", rdata, rd_pat(33'h3000)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0; cmd_valid = 0; cmd_is_wr = 0; cmd_addr = '0; cmd_num = '0; cmd_stride = '0;
    wdata_valid = 0; rdata_ready = 0;
    test_reset();
    test_write();
    test_read_backpressure();
    test_zero_num();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
